// File: rtl/axis_forwarder.sv
// axis_forwarder
// Claims the packet buffer P3 offers on its fwd port, reads it word by word
// and emits it as AXI-Stream. A credit-limited skid FIFO absorbs P3's
// variable read latency so m_tready backpressure never loses a word.
// Once the last beat has left the FIFO, fwd_done is held until P3 acks.
//
// Ports
//   clk, rst                 clock (rising edge); asynchronous active-low reset
//   rdy_for_fwd / _ack       P3 has a packet / one-cycle claim pulse
//   fwd_addr, fwd_rd_en      word read address and strobe into P3
//   fwd_rd_data(_vld)        read data, returned in issue order
//   fwd_byte_len             packet length in bytes, stable while claimed
//   fwd_done / fwd_done_ack  packet finished (level) / buffer released
//   m_t*                     AXI-Stream master; byte 0 in the top byte lane
module axis_forwarder #(
    parameter int FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH     = 64,
    parameter int PLEN_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    localparam int KEEP_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy_for_fwd,
    output logic                      rdy_for_fwd_ack,
    output logic [FWD_ADDR_WIDTH-1:0] fwd_addr,
    output logic                      fwd_rd_en,
    input  logic [DATA_WIDTH-1:0]     fwd_rd_data,
    input  logic                      fwd_rd_data_vld,
    input  logic [PLEN_WIDTH-1:0]     fwd_byte_len,
    output logic                      fwd_done,
    input  logic                      fwd_done_ack,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [KEEP_WIDTH-1:0]     m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = FWD_ADDR_WIDTH + 1;
    localparam int RW = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, LEN, READ, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [WW-1:0]             words, rd_cnt, push_cnt;
    logic [KEEP_WIDTH-1:0]     last_keep;
    logic [FWD_ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]             in_flight, count;
    logic [PW-1:0]             wr_ptr, rd_ptr;

    logic [DATA_WIDTH-1:0]     mem_data [FIFO_DEPTH];
    logic [KEEP_WIDTH-1:0]     mem_keep [FIFO_DEPTH];
    logic                      mem_last [FIFO_DEPTH];

    // Length decode, used in LEN while fwd_byte_len is stable.
    logic [PLEN_WIDTH:0]   words_full;
    logic [RW-1:0]         rem;
    logic                  trunc;
    logic [WW-1:0]         words_n;
    logic [KEEP_WIDTH-1:0] keep_n;

    always_comb begin
        words_full = ({1'b0, fwd_byte_len} + (PLEN_WIDTH+1)'(KEEP_WIDTH - 1))
                     / (PLEN_WIDTH+1)'(KEEP_WIDTH);
        rem        = RW'(fwd_byte_len % PLEN_WIDTH'(KEEP_WIDTH));
        trunc      = words_full > (PLEN_WIDTH+1)'(2**FWD_ADDR_WIDTH);
        words_n    = trunc ? WW'(2**FWD_ADDR_WIDTH) : WW'(words_full);
        keep_n     = (rem == '0 || trunc) ? {KEEP_WIDTH{1'b1}}
                                          : ~({KEEP_WIDTH{1'b1}} >> rem);
    end

    logic fifo_empty, push, pop, credit_ok, rd_issue;

    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && m_tready;
    // A vld with nothing outstanding is a P3 protocol error; drop it.
    assign push       = fwd_rd_data_vld && (in_flight != '0);
    // Every issued read is guaranteed a FIFO slot when its data returns.
    assign credit_ok  = ({1'b0, in_flight} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
    assign rd_issue   = (state == READ) && credit_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rdy_for_fwd) state_nxt = LEN;
            LEN:     state_nxt = (words_n == '0) ? DONE : READ;
            READ:    if (rd_issue && (rd_cnt + WW'(1)) == words) state_nxt = DRAIN;
            DRAIN:   if (in_flight == '0 && fifo_empty) state_nxt = DONE;
            DONE:    if (fwd_done_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            words     <= '0;
            last_keep <= '0;
            addr      <= '0;
            rd_cnt    <= '0;
            push_cnt  <= '0;
            in_flight <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (state == LEN) begin
                words     <= words_n;
                last_keep <= keep_n;
                addr      <= '0;
                rd_cnt    <= '0;
                push_cnt  <= '0;
            end
            if (rd_issue) begin
                addr   <= addr + FWD_ADDR_WIDTH'(1);
                rd_cnt <= rd_cnt + WW'(1);
            end
            if (rd_issue && !push)      in_flight <= in_flight + CW'(1);
            else if (!rd_issue && push) in_flight <= in_flight - CW'(1);
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                push_cnt <= push_cnt + WW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Beat position is resolved on push so the FIFO head carries its own
    // keep/last and stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= fwd_rd_data;
            mem_last[wr_ptr] <= (push_cnt + WW'(1)) == words;
            mem_keep[wr_ptr] <= ((push_cnt + WW'(1)) == words) ? last_keep
                                                               : {KEEP_WIDTH{1'b1}};
        end
    end

    // Claim is combinational from IDLE; rst gating keeps it low while the
    // block is held in reset even if P3 is already offering.
    assign rdy_for_fwd_ack = (state == IDLE) && rdy_for_fwd && rst;
    assign fwd_rd_en       = rd_issue;
    assign fwd_addr        = addr;
    assign fwd_done        = (state == DONE);
    assign m_tvalid        = !fifo_empty;
    assign m_tdata         = fifo_empty ? '0 : mem_data[rd_ptr];
    assign m_tkeep         = fifo_empty ? '0 : mem_keep[rd_ptr];
    assign m_tlast         = fifo_empty ? 1'b0 : mem_last[rd_ptr];

endmodule

// File: tb/tb_axis_forwarder.sv
module tb_axis_forwarder;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int PL = 32;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy_for_fwd, rdy_for_fwd_ack;
    logic [AW-1:0] fwd_addr;
    logic          fwd_rd_en;
    logic [DW-1:0] fwd_rd_data;
    logic          fwd_rd_data_vld;
    logic [PL-1:0] fwd_byte_len;
    logic          fwd_done, fwd_done_ack;
    logic [DW-1:0] m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;

    always #5 clk = ~clk;

    axis_forwarder #(.FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
        .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
        .fwd_rd_data(fwd_rd_data), .fwd_rd_data_vld(fwd_rd_data_vld),
        .fwd_byte_len(fwd_byte_len),
        .fwd_done(fwd_done), .fwd_done_ack(fwd_done_ack),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    // P3 read port model: fixed latency `lat` cycles, data = {pid, addr}.
    int          lat = 1;
    logic [31:0] pid = '0;
    logic          p_v [4];
    logic [AW-1:0] p_a [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin p_v[i] <= 1'b0; p_a[i] <= '0; end
        end else begin
            p_v[0] <= fwd_rd_en;
            p_a[0] <= fwd_addr;
            for (int i = 1; i < 4; i++) begin p_v[i] <= p_v[i-1]; p_a[i] <= p_a[i-1]; end
        end
    end
    assign fwd_rd_data_vld = p_v[lat-1];
    assign fwd_rd_data     = {pid, 23'h0, p_a[lat-1]};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   rdy_for_fwd_ack, 0);
        chk({tag, "_rd_en"}, fwd_rd_en, 0);
        chk({tag, "_addr"},  fwd_addr, 0);
        chk({tag, "_done"},  fwd_done, 0);
        chk({tag, "_tvalid"}, m_tvalid, 0);
        chk({tag, "_tlast"}, m_tlast, 0);
        chk({tag, "_tkeep"}, m_tkeep, 0);
        chk({tag, "_tdata"}, m_tdata, 0);
    endtask

    // One packet: claim, stream, check every read and beat, ack done.
    // mode 0: tready held 1 (beats must be back to back); mode 1: random tready.
    task automatic run_pkt(input int len, input int mode, input int exp_words, input logic [7:0] exp_lkeep);
        int issued = 0, beats = 0, cyc = 0, prev = 0;
        bit hold = 0;
        logic [DW-1:0] hold_data = '0;
        @(negedge clk);
        rdy_for_fwd = 1; fwd_byte_len = len; m_tready = 1;
        #1 chk("claim_ack", rdy_for_fwd_ack, 1);
        do begin
            @(negedge clk);
            cyc++;
            rdy_for_fwd = 0;
            m_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 1) chk("ack_one_cycle", rdy_for_fwd_ack, 0);
            if (hold) chk("hold_tdata", m_tdata, hold_data);
            hold = m_tvalid && !m_tready;
            hold_data = m_tdata;
            if (fwd_rd_en) begin
                chk("rd_addr", fwd_addr, issued);
                issued++;
            end
            if (m_tvalid && m_tready) begin
                chk("beat_in_range", beats < exp_words, 1);
                chk("tdata", m_tdata, {pid, 32'(beats)});
                chk("tkeep", m_tkeep, (beats == exp_words - 1) ? exp_lkeep : 8'hFF);
                chk("tlast", m_tlast, beats == exp_words - 1);
                if (mode == 0 && beats > 0) chk("back_to_back", cyc, prev + 1);
                prev = cyc;
                beats++;
            end
            chk("credit", (issued - beats) <= FD, 1);
        end while (!fwd_done && cyc < 3000);
        chk("done_seen", fwd_done, 1);
        chk("beat_count", beats, exp_words);
        chk("read_count", issued, exp_words);
        chk("tvalid_at_done", m_tvalid, 0);
        if (len == 0) chk("zero_len_done_latency", cyc, 2);
        fwd_done_ack = 1;
        @(negedge clk);
        fwd_done_ack = 0;
        #1 chk("done_released", fwd_done, 0);
    endtask

    initial begin
        int pops;
        rst = 0; rdy_for_fwd = 1; fwd_byte_len = 64; fwd_done_ack = 0; m_tready = 1;
        #12 chk_all_zero("reset");
        @(negedge clk); rdy_for_fwd = 0; rst = 1;
        @(negedge clk);

        lat = 1; pid = 1; run_pkt(64, 0, 8, 8'hFF);     // T1
        lat = 1; pid = 2; run_pkt(13, 0, 2, 8'hF8);     // T2
        lat = 1; pid = 3; run_pkt(0, 0, 0, 8'hFF);      // T3
        lat = 3; pid = 4; run_pkt(256, 1, 32, 8'hFF);   // T4
        lat = 1; pid = 5; run_pkt(5000, 0, 512, 8'hFF); // T5: truncated
        lat = 2; pid = 8; run_pkt(9, 1, 2, 8'h80);      // one byte in last beat
        lat = 2; pid = 9; run_pkt(7, 0, 1, 8'hFE);      // single short beat

        // T6: reset during READ after 3 beats
        lat = 2; pid = 6; pops = 0;
        @(negedge clk); rdy_for_fwd = 1; fwd_byte_len = 64; m_tready = 1;
        for (int c = 0; c < 50 && pops < 3; c++) begin
            @(negedge clk); rdy_for_fwd = 0; #1;
            if (m_tvalid && m_tready) pops++;
        end
        chk("t6_beats_before_reset", pops, 3);
        @(posedge clk); #2 rst = 0;
        #1 chk_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        lat = 2; pid = 7; run_pkt(16, 0, 2, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
